rate_limiter: RTL and testbench

RATE_LIMITER -- requirements
Module: rate_limiter

---
 rtl/rate_limiter.sv | 195 +++++++++++++++++++
 tb/tb_rate_limiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_limiter.sv
// -----------------------------------------------------------------------------
// rate_limiter
//
// Packet-aware word rate limiter. Upstream words are buffered in a FIFO of
// 2^FIFO_DEPTH_BITS entries. A token-bucket credit counter, refilled by a
// programmable periodic tick, gates the start of each packet. Once the first
// word of a packet has been released, the rest of the packet follows without
// any further credit check, so packets are never split by the limiter.
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   reset                synchronous active-high reset
//   in_data / in_ctrl    upstream word and control byte (ctrl != 0 marks
//                        module-header and end-of-packet words)
//   in_wr                upstream write strobe
//   in_rdy               upstream may write next cycle (FIFO not nearly full)
//   out_data / out_ctrl  downstream word, valid one cycle after the FIFO read
//   out_wr               downstream write strobe
//   out_rdy              downstream can accept a word
//   cfg_en               1 = limiting active, 0 = pass-through
//   cfg_interval         tick period minus one, in cycles
//   cfg_credit_per_tick  word credits added on each tick
//   cfg_max_credit       credit saturation ceiling
//   pkt_count            packets forwarded since reset (wraps)
//   stalled              a packet waits at the FIFO head for credit
// -----------------------------------------------------------------------------
module rate_limiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = 8,
  parameter int FIFO_DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_en,
  input  logic [15:0]           cfg_interval,
  input  logic [15:0]           cfg_credit_per_tick,
  input  logic [19:0]           cfg_max_credit,
  output logic [31:0]           pkt_count,
  output logic                  stalled
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_CNT  = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] NEARLY_CNT = DEPTH_CNT - 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,  // head word is the first word of a packet
    ST_HDR,   // inside the module-header words
    ST_BODY   // inside the body, waiting for end-of-packet
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]      mem_data [DEPTH];
  logic [CTRL_WIDTH-1:0]      mem_ctrl [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic fifo_wr;
  logic fifo_rd;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_wr    = in_wr && !fifo_full;
  assign head_ctrl  = mem_ctrl[rd_ptr_q];
  assign in_rdy     = (count_q < NEARLY_CNT);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic [19:0]   credit_q, credit_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic          out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic          tick;
  logic          permit;
  logic          credit_dec;
  logic [20:0]   credit_sum;

  assign tick = (tick_cnt_q == cfg_interval);

  // The credit gate only applies to the first word of a packet; mid-packet
  // words are always released so a started packet is never split.
  assign permit  = (state_q != ST_IDLE) || !cfg_en || (credit_q != '0);
  assign fifo_rd = !fifo_empty && out_rdy && permit;

  assign stalled = (state_q == ST_IDLE) && !fifo_empty && out_rdy &&
                   cfg_en && (credit_q == '0);

  assign credit_dec = fifo_rd && cfg_en;

  // NOTE: combinational blocks use blocking '=' and every output gets a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pkt_count_d = pkt_count_q;
    if (fifo_rd) begin
      unique case (state_q)
        ST_IDLE: state_d = (head_ctrl != '0) ? ST_HDR : ST_BODY;
        ST_HDR:  if (head_ctrl == '0) state_d = ST_BODY;
        ST_BODY: begin
          if (head_ctrl != '0) begin
            state_d     = ST_IDLE;
            pkt_count_d = pkt_count_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_DEPTH_BITS'(fifo_wr);
    rd_ptr_d   = rd_ptr_q + FIFO_DEPTH_BITS'(fifo_rd);
    count_d    = count_q + (FIFO_DEPTH_BITS + 1)'(fifo_wr)
                         - (FIFO_DEPTH_BITS + 1)'(fifo_rd);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
  end

  // Refill and consumption are applied as one net update, then floored at 0
  // and clamped to the ceiling (which also pulls credit down if the ceiling
  // is lowered at run time).
  always_comb begin
    credit_sum = {1'b0, credit_q} + (tick ? {5'd0, cfg_credit_per_tick} : 21'd0);
    if (credit_dec && (credit_sum != '0)) begin
      credit_sum = credit_sum - 21'd1;
    end
    if (credit_sum > {1'b0, cfg_max_credit}) begin
      credit_d = cfg_max_credit;
    end else begin
      credit_d = credit_sum[19:0];
    end
  end

  // NOTE: sequential blocks use non-blocking '<=' so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      credit_q    <= '0;
      pkt_count_q <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      credit_q    <= credit_d;
      pkt_count_q <= pkt_count_d;
      out_wr_q    <= fifo_rd;
    end
  end

  // NOTE: storage and the output data register carry no reset; emptying the
  // FIFO is done by the pointers and out_wr qualifies the data, so stale
  // contents are never observed.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_ctrl[wr_ptr_q] <= in_ctrl;
    end
    if (fifo_rd) begin
      out_data_q <= mem_data[rd_ptr_q];
      out_ctrl_q <= mem_ctrl[rd_ptr_q];
    end
  end

  assign out_wr    = out_wr_q;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_rate_limiter.sv
// -----------------------------------------------------------------------------
// tb_rate_limiter
//
// Directed bench for rate_limiter. Inputs are driven on the falling edge;
// outputs are sampled 1 time unit after the rising edge. Every written word is
// queued as an expected word and popped when the DUT emits it. Packets are
// 10 words: 2 header words (ctrl 0xFF), 7 body words (ctrl 0), 1 EOP (0x80).
// The low 16 data bits carry the word index inside its packet.
// -----------------------------------------------------------------------------
module tb_rate_limiter;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_interval = 16'd9;
  logic [15:0] cfg_credit_per_tick = 16'd1;
  logic [19:0] cfg_max_credit = 20'd100;
  logic [31:0] pkt_count;
  logic        stalled;

  rate_limiter dut (
    .clk                 (clk),
    .reset               (reset),
    .in_data             (in_data),
    .in_ctrl             (in_ctrl),
    .in_wr               (in_wr),
    .in_rdy              (in_rdy),
    .out_data            (out_data),
    .out_ctrl            (out_ctrl),
    .out_wr              (out_wr),
    .out_rdy             (out_rdy),
    .cfg_en              (cfg_en),
    .cfg_interval        (cfg_interval),
    .cfg_credit_per_tick (cfg_credit_per_tick),
    .cfg_max_credit      (cfg_max_credit),
    .pkt_count           (pkt_count),
    .stalled             (stalled)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    c0    = 0;
  int    out_cnt = 0;
  int    first_out_cyc = 0;
  int    last_out_cyc  = 0;
  int    gaps = 0;
  int    written = 0;
  bit    in_pkt = 1'b0;
  bit    stalled_seen = 1'b0;
  word_t exp_q[$];
  int    starts[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input int id, input int idx);
    word_t w;
    w.data = {16'hC0DE, 16'(id * 37), 16'(id), 16'(idx)};
    w.ctrl = (idx < 2) ? 8'hFF : ((idx == 9) ? 8'h80 : 8'h00);
    return w;
  endfunction

  // Output monitor and scoreboard.
  always @(posedge clk) begin
    word_t e;
    cyc++;
    #1;
    if (out_wr) begin
      if (exp_q.size() == 0) begin
        check("out_extra", out_wr, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_ctrl", out_ctrl, e.ctrl);
      end
      out_cnt++;
      if (out_cnt == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (out_data[15:0] == 16'd0) begin
        starts.push_back(cyc);
        in_pkt = 1'b1;
      end
      if (out_data[15:0] == 16'd9) in_pkt = 1'b0;
    end else if (in_pkt) begin
      gaps++;
    end
    if (stalled) stalled_seen = 1'b1;
  end

  task automatic clear_obs();
    exp_q.delete();
    starts.delete();
    out_cnt = 0;
    gaps = 0;
    written = 0;
    in_pkt = 1'b0;
    stalled_seen = 1'b0;
  endtask

  // Applies config, holds reset for 3 cycles and releases it on a falling
  // edge; the cycle containing that edge is cycle 0 (c0).
  task automatic do_reset(input logic en, input logic [15:0] intv,
                          input logic [15:0] cpt, input logic [19:0] maxc);
    cfg_en = en;
    cfg_interval = intv;
    cfg_credit_per_tick = cpt;
    cfg_max_credit = maxc;
    reset = 1'b1;
    in_wr = 1'b0;
    repeat (3) @(negedge clk);
    clear_obs();
    reset = 1'b0;
    c0 = cyc;
  endtask

  task automatic send_word(input word_t w);
    int k;
    k = 0;
    while (!in_rdy && k < 5000) begin
      in_wr = 1'b0;
      @(negedge clk);
      k++;
    end
    if (!in_rdy) check("in_rdy_timeout", in_rdy, 1'b1);
    in_data = w.data;
    in_ctrl = w.ctrl;
    in_wr = 1'b1;
    exp_q.push_back(w);
    written++;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int id);
    for (int i = 0; i < 10; i++) send_word(mk(id, i));
  endtask

  task automatic idle();
    in_wr = 1'b0;
  endtask

  task automatic wait_out(input int n, input int bound);
    int k;
    k = 0;
    while (out_cnt < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  initial begin
    int x;
    int occ;

    // Reset state
    @(negedge clk);
    do_reset(1'b0, 16'd9, 16'd1, 20'd100);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_stalled", stalled, 1'b0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_credit", dut.credit_q, 20'd0);

    // Pass-through, three packets
    x = cyc;
    for (int p = 0; p < 3; p++) send_pkt(p);
    idle();
    wait_out(30, 300);
    check("pt_out_cnt", out_cnt, 30);
    check("pt_latency", first_out_cyc - x, 2);
    check("pt_pkt_count", pkt_count, 32'd3);
    check("pt_stalled", stalled_seen, 1'b0);
    check("pt_leftover", exp_q.size(), 0);

    // Limited, interval 9, 1 credit per tick: each packet waits for a tick
    // with zero credit, so packet starts are 20 cycles apart.
    do_reset(1'b1, 16'd9, 16'd1, 20'd100);
    for (int p = 10; p < 15; p++) send_pkt(p);
    idle();
    wait_out(50, 2000);
    check("lim_out_cnt", out_cnt, 50);
    check("lim_starts", starts.size(), 5);
    if (starts.size() == 5) begin
      check("lim_first_start", starts[0] - c0, 11);
      for (int i = 1; i < 5; i++) check("lim_spacing", starts[i] - starts[i-1], 20);
    end
    check("lim_gaps", gaps, 0);
    check("lim_stalled_seen", stalled_seen, 1'b1);
    check("lim_pkt_count", pkt_count, 32'd5);

    // First packet held until the first tick at cycle 65535
    do_reset(1'b1, 16'hFFFF, 16'd1, 20'd100);
    send_pkt(20);
    idle();
    repeat (60000) @(negedge clk);
    check("hold_stalled", stalled, 1'b1);
    check("hold_out_wr", out_wr, 1'b0);
    check("hold_out_cnt", out_cnt, 0);
    wait_out(10, 10000);
    check("hold_out_total", out_cnt, 10);
    check("hold_first", first_out_cyc - c0, 65537);
    check("hold_last", last_out_cyc - c0, 65546);
    check("hold_pkt_count", pkt_count, 32'd1);

    // Credit saturation: max 5, +4 per tick, tick every cycle, no traffic
    do_reset(1'b1, 16'd0, 16'd4, 20'd5);
    for (int i = 0; i <= 10; i++) begin
      check("sat_credit", dut.credit_q, (i == 0) ? 20'd0 : ((i == 1) ? 20'd4 : 20'd5));
      @(negedge clk);
    end

    // Back-pressure: out_rdy low mid-packet, continuous input
    do_reset(1'b0, 16'd9, 16'd1, 20'd100);
    for (int n = 0; n < 3; n++) send_word(mk(30, n));
    out_rdy = 1'b0;
    x = 3;
    while (in_rdy && x < 100) begin
      word_t w;
      w = mk(30 + x / 10, x % 10);
      in_data = w.data;
      in_ctrl = w.ctrl;
      in_wr = 1'b1;
      exp_q.push_back(w);
      written++;
      x++;
      @(negedge clk);
    end
    idle();
    occ = written - out_cnt;
    check("bp_in_rdy_low", in_rdy, 1'b0);
    check("bp_occupancy", occ, 31);
    repeat (50 - (x - 3)) @(negedge clk);
    check("bp_no_out", out_cnt, written - 31);
    out_rdy = 1'b1;
    for (int n = x; n < 40; n++) send_word(mk(30 + n / 10, n % 10));
    idle();
    wait_out(40, 500);
    check("bp_out_cnt", out_cnt, 40);
    check("bp_leftover", exp_q.size(), 0);
    check("bp_pkt_count", pkt_count, 32'd4);

    // Reset on word 4 of a packet
    for (int n = 0; n < 3; n++) send_word(mk(40, n));
    in_data = mk(40, 3).data;
    in_ctrl = mk(40, 3).ctrl;
    reset = 1'b1;
    clear_obs();
    @(negedge clk);
    in_wr = 1'b0;
    check("mid_rst_out_wr", out_wr, 1'b0);
    check("mid_rst_pkt_count", pkt_count, 32'd0);
    check("mid_rst_in_rdy", in_rdy, 1'b1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_out", out_cnt, 0);
    check("mid_rst_empty", dut.count_q, 6'd0);
    send_pkt(41);
    idle();
    wait_out(10, 300);
    check("mid_rst_next_cnt", out_cnt, 10);
    check("mid_rst_leftover", exp_q.size(), 0);
    check("mid_rst_next_pkts", pkt_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
